// File: rtl/clk_switch_pkg.sv
// clk_switch_pkg: shared state encoding and mux select polarity for the clock switch controller
package clk_switch_pkg;

    typedef enum logic [1:0] {
        ON_A    = 2'd0,
        SW_TO_B = 2'd1,
        ON_B    = 2'd2,
        SW_TO_A = 2'd3
    } state_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/clk_presence_mon.sv
// clk_presence_mon: judges clkB present when enough divided-clkB edges land in each clkA window
module clk_presence_mon #(
    parameter int DIV_W       = 2,
    parameter int WIN_W       = 8,
    parameter int MIN_EDGES   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clkA,
    input  logic rst,
    input  logic clkB,
    output logic clkb_ok
);

    localparam int EDGE_W = $clog2(MIN_EDGES + 1);
    localparam logic [EDGE_W-1:0] MIN_E = EDGE_W'(MIN_EDGES);

    logic [DIV_W-1:0]       div;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic [WIN_W-1:0]       win;
    logic [EDGE_W-1:0]      edges;
    logic                   rise;

    assign rise = sync[SYNC_STAGES-1] & ~prev;

    // free-running prescaler in the clkB domain; its value never matters, only its MSB toggling
    always_ff @(posedge clkB)
        div <= div + 1'b1;

    // bring the divided clock MSB into clkA through a plain flop chain
    always_ff @(posedge clkA)
        if (rst)
            sync <= '0;
        else
            sync <= {sync[SYNC_STAGES-2:0], div[DIV_W-1]};

    // count synchronized rising edges per window and publish the verdict on the last window cycle
    always_ff @(posedge clkA)
        if (rst) begin
            prev    <= 1'b0;
            win     <= '0;
            edges   <= '0;
            clkb_ok <= 1'b0;
        end else begin
            prev <= sync[SYNC_STAGES-1];
            win  <= win + 1'b1;
            if (&win) begin
                clkb_ok <= edges >= MIN_E;
                edges   <= '0;
            end else if (rise && !(&edges)) begin
                edges <= edges + 1'b1;
            end
        end

endmodule

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: drives the glitch-free mux select between clkA and clkB with settling and clkB-loss fallback
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int DIV_W       = 2,
    parameter int WIN_W       = 8,
    parameter int MIN_EDGES   = 4,
    parameter int SETTLE_CYC  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clkA,
    input  logic rst,
    input  logic clkB,
    input  logic req_b,
    input  logic fault_clr,
    output logic select,
    output logic on_b,
    output logic busy,
    output logic clkb_ok,
    output logic fault
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYC - 1);

    state_t           state, state_n;
    logic             sel_n, fault_set, fault_n;
    logic [SET_W-1:0] settle, settle_n;

    clk_presence_mon #(
        .DIV_W      (DIV_W),
        .WIN_W      (WIN_W),
        .MIN_EDGES  (MIN_EDGES),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_mon (
        .clkA   (clkA),
        .rst    (rst),
        .clkB   (clkB),
        .clkb_ok(clkb_ok)
    );

    assign on_b = state == ON_B;
    assign busy = (state == SW_TO_B) || (state == SW_TO_A);

    // next state, select and settle count; a lost clkB always forces the mux back to clkA
    always_comb begin
        state_n   = state;
        sel_n     = select;
        settle_n  = settle;
        fault_set = 1'b0;
        case (state)
            ON_A:
                if (req_b && clkb_ok && !fault) begin
                    sel_n    = SEL_B;
                    settle_n = SETTLE_LD;
                    state_n  = SW_TO_B;
                end
            SW_TO_B:
                if (!clkb_ok) begin
                    fault_set = 1'b1;
                    sel_n     = SEL_A;
                    settle_n  = SETTLE_LD;
                    state_n   = SW_TO_A;
                end else if (settle == '0) begin
                    state_n = ON_B;
                end else begin
                    settle_n = settle - 1'b1;
                end
            ON_B:
                if (!clkb_ok || !req_b) begin
                    fault_set = !clkb_ok;
                    sel_n     = SEL_A;
                    settle_n  = SETTLE_LD;
                    state_n   = SW_TO_A;
                end
            SW_TO_A:
                if (settle == '0)
                    state_n = ON_A;
                else
                    settle_n = settle - 1'b1;
            default:
                state_n = ON_A;
        endcase
        fault_n = fault_set | (fault & ~fault_clr);
    end

    // control state registers; a new fault outranks a simultaneous clear
    always_ff @(posedge clkA)
        if (rst) begin
            state  <= ON_A;
            select <= SEL_A;
            settle <= '0;
            fault  <= 1'b0;
        end else begin
            state  <= state_n;
            select <= sel_n;
            settle <= settle_n;
            fault  <= fault_n;
        end

endmodule
